ahbl_splitter_n: RTL and testbench

Parametrised AHB-Lite slave-side splitter: decodes one tag field of `HADDR` to up to eight downstream slaves, then multiplexes their data-phase responses back to the master port. Sits below the system bus decoder, in front of GPIO/peripheral banks. It extends a fixed three-way GPIO splitter with:
- configurable slave count and decode field;
- a built-in default slave returning a proper two-cycle AHB ERROR for unmapped active transfers;
- a hung-slave watchdog with a sticky interrupt.

---
 rtl/ahbl_splitter_n.sv | 157 +++++++++++++++
 tb/tb_ahbl_splitter_n.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_splitter_n.sv
// AHB-Lite slave-side splitter: decodes an HADDR tag field to up to eight
// slaves, muxes their data-phase responses back, answers unmapped active
// transfers with a two-cycle ERROR, and watches for hung slaves.
module ahbl_splitter_n #(
  parameter int unsigned              NSLV      = 4,
  parameter int unsigned              DEC_LSB   = 24,
  parameter int unsigned              DEC_W     = 4,
  parameter logic [NSLV*DEC_W-1:0]    TAGS      = {4'h3, 4'h2, 4'h1, 4'h0},
  parameter logic [31:0]              DEF_RDATA = 32'hBADDBEEF,
  parameter int unsigned              TO_CYCLES = 256
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HREADY,
  input  logic                 HSEL,
  output logic                 HREADYOUT,
  output logic                 HRESP,
  output logic [31:0]          HRDATA,
  output logic [NSLV-1:0]      S_SEL,
  input  logic [NSLV-1:0]      S_HREADYOUT,
  input  logic [NSLV-1:0]      S_HRESP,
  input  logic [32*NSLV-1:0]   S_HRDATA,
  input  logic                 TIMEOUT_CLR,
  output logic                 TIMEOUT_IRQ,
  output logic [2:0]           TO_SLV
);

  localparam int unsigned CNT_W = 16;
  localparam bit               WD_EN  = (TO_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TO_CYCLES);
  localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TO_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } dst_t;

  logic [DEC_W-1:0] field;
  logic [NSLV-1:0]  match;
  logic             taken;
  logic             unmapped_active;
  logic [NSLV-1:0]  sel_d;
  dst_t             dst_q, dst_nxt;
  logic             def_ready, def_resp;
  logic [CNT_W-1:0] wcnt;
  logic             to_flag;
  logic             waiting;
  logic             wd_inc;
  logic             to_set;
  logic [2:0]       sel_idx;
  logic             unused_bits;

  // Address bits outside the decode field and HTRANS[0] carry no meaning here
  assign unused_bits = ^{HADDR, HTRANS[0]};

  // Tag decode with lowest-index priority so S_SEL is one-hot or zero
  always_comb begin
    field = HADDR[DEC_LSB +: DEC_W];
    taken = 1'b0;
    match = '0;
    S_SEL = '0;
    for (int i = 0; i < int'(NSLV); i++) begin
      match[i] = (field == TAGS[i*DEC_W +: DEC_W]);
      S_SEL[i] = HSEL & match[i] & ~taken;
      taken    = taken | match[i];
    end
  end

  assign unmapped_active = HSEL & HTRANS[1] & ~(|match);

  // Data-phase owner, advanced only on accepted address phases
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    sel_d <= '0;
    else if (HREADY) sel_d <= S_SEL;
  end

  // Default-slave state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) dst_q <= ST_IDLE;
    else          dst_q <= dst_nxt;
  end

  // Default-slave next state and two-cycle ERROR response
  always_comb begin
    dst_nxt   = dst_q;
    def_ready = 1'b1;
    def_resp  = 1'b0;
    case (dst_q)
      ST_IDLE: begin
        if (HREADY && unmapped_active) dst_nxt = ST_ERR1;
      end
      ST_ERR1: begin
        def_ready = 1'b0;
        def_resp  = 1'b1;
        dst_nxt   = ST_ERR2;
      end
      ST_ERR2: begin
        def_resp = 1'b1;
        if (HREADY && unmapped_active) dst_nxt = ST_ERR1;
        else                           dst_nxt = ST_IDLE;
      end
      default: dst_nxt = ST_IDLE;
    endcase
  end

  // Response mux: data-phase slave owns the bus, else the default slave
  always_comb begin
    HREADYOUT = def_ready;
    HRESP     = def_resp;
    HRDATA    = DEF_RDATA;
    for (int i = 0; i < int'(NSLV); i++) begin
      if (sel_d[i]) begin
        HREADYOUT = S_HREADYOUT[i];
        HRESP     = S_HRESP[i];
        HRDATA    = S_HRDATA[i*32 +: 32];
      end
    end
  end

  // Selected slave index and wait detection for the watchdog
  always_comb begin
    sel_idx = 3'd0;
    for (int i = 0; i < int'(NSLV); i++) begin
      if (sel_d[i]) sel_idx = 3'(i);
    end
  end

  assign waiting = (|sel_d) & ~(|(sel_d & S_HREADYOUT));
  assign wd_inc  = WD_EN & waiting & ~HREADY;
  assign to_set  = wd_inc & (wcnt == TO_M1);

  // Consecutive wait-cycle counter, saturating at the limit
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                     wcnt <= '0;
    else if (HREADY)                  wcnt <= '0;
    else if (wd_inc && wcnt != TO_LIM) wcnt <= wcnt + CNT_W'(1);
  end

  // Sticky timeout flag; a new timeout beats a coincident clear
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)         to_flag <= 1'b0;
    else if (to_set)      to_flag <= 1'b1;
    else if (TIMEOUT_CLR) to_flag <= 1'b0;
  end

  // First timed-out slave is kept until the flag is cleared
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                TO_SLV <= 3'd0;
    else if (to_set && !to_flag) TO_SLV <= sel_idx;
  end

  assign TIMEOUT_IRQ = to_flag;

endmodule

// File: tb/tb_ahbl_splitter_n.sv
// Directed bench for ahbl_splitter_n: mapped read, default-slave errors,
// duplicate tags, watchdog and asynchronous reset.
module tb_ahbl_splitter_n;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic         hready;
  logic         hsel;
  logic         hreadyout, hresp;
  logic [31:0]  hrdata;
  logic [3:0]   s_sel;
  logic [3:0]   s_hreadyout;
  logic [3:0]   s_hresp;
  logic [127:0] s_hrdata;
  logic         timeout_clr;
  logic         timeout_irq;
  logic [2:0]   to_slv;

  logic         dup_hreadyout, dup_hresp, dup_irq;
  logic [31:0]  dup_hrdata;
  logic [3:0]   dup_s_sel;
  logic [2:0]   dup_to_slv;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 HCLK = ~HCLK;

  // Master sees the splitter's own ready as the bus ready
  assign hready = hreadyout;

  ahbl_splitter_n #(.TO_CYCLES(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(haddr), .HTRANS(htrans),
    .HREADY(hready), .HSEL(hsel), .HREADYOUT(hreadyout), .HRESP(hresp),
    .HRDATA(hrdata), .S_SEL(s_sel), .S_HREADYOUT(s_hreadyout),
    .S_HRESP(s_hresp), .S_HRDATA(s_hrdata), .TIMEOUT_CLR(timeout_clr),
    .TIMEOUT_IRQ(timeout_irq), .TO_SLV(to_slv)
  );

  ahbl_splitter_n #(.TAGS({4'h1, 4'h1, 4'h1, 4'h0})) dut_dup (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(haddr), .HTRANS(htrans),
    .HREADY(hready), .HSEL(hsel), .HREADYOUT(dup_hreadyout), .HRESP(dup_hresp),
    .HRDATA(dup_hrdata), .S_SEL(dup_s_sel), .S_HREADYOUT(s_hreadyout),
    .S_HRESP(s_hresp), .S_HRDATA(s_hrdata), .TIMEOUT_CLR(timeout_clr),
    .TIMEOUT_IRQ(dup_irq), .TO_SLV(dup_to_slv)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    haddr  = 32'h0;
  endtask

  initial begin
    HRESETn     = 1'b0;
    bus_idle();
    s_hreadyout = 4'hF;
    s_hresp     = 4'h0;
    s_hrdata    = '0;
    timeout_clr = 1'b0;
    #12;
    check_eq("rst_hreadyout", 32'(hreadyout), 32'd1);
    check_eq("rst_hresp", 32'(hresp), 32'd0);
    check_eq("rst_hrdata", hrdata, 32'hBADDBEEF);
    check_eq("rst_irq", 32'(timeout_irq), 32'd0);
    check_eq("rst_to_slv", 32'(to_slv), 32'd0);
    HRESETn = 1'b1;
    tick();

    // Mapped read to slave 2 with one wait state
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0200_0000;
    #1 check_eq("map_s_sel", 32'(s_sel), 32'h4);
    tick();
    bus_idle();
    s_hreadyout[2] = 1'b0;
    #1 check_eq("map_wait_ready", 32'(hreadyout), 32'd0);
    tick();
    s_hreadyout[2] = 1'b1;
    s_hrdata[2*32 +: 32] = 32'h1234_5678;
    #1;
    check_eq("map_ready", 32'(hreadyout), 32'd1);
    check_eq("map_hrdata", hrdata, 32'h1234_5678);
    check_eq("map_hresp", 32'(hresp), 32'd0);
    tick();
    check_eq("map_done_hrdata", hrdata, 32'hBADDBEEF);

    // Unmapped NONSEQ, then back-to-back unmapped NONSEQ in ERR2
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0700_0000;
    #1 check_eq("unm_s_sel", 32'(s_sel), 32'h0);
    tick();
    htrans = 2'b00;
    #1;
    check_eq("err1_ready", 32'(hreadyout), 32'd0);
    check_eq("err1_resp", 32'(hresp), 32'd1);
    check_eq("err1_hrdata", hrdata, 32'hBADDBEEF);
    tick();
    check_eq("err2_ready", 32'(hreadyout), 32'd1);
    check_eq("err2_resp", 32'(hresp), 32'd1);
    htrans = 2'b10;
    tick();
    htrans = 2'b00;
    #1;
    check_eq("b2b_err1_ready", 32'(hreadyout), 32'd0);
    check_eq("b2b_err1_resp", 32'(hresp), 32'd1);
    tick();
    check_eq("b2b_err2_ready", 32'(hreadyout), 32'd1);
    check_eq("b2b_err2_resp", 32'(hresp), 32'd1);
    tick();
    check_eq("b2b_idle_resp", 32'(hresp), 32'd0);

    // Unmapped IDLE transfer completes OKAY with no wait
    hsel = 1'b1; htrans = 2'b00; haddr = 32'h0700_0000;
    tick();
    check_eq("unm_idle_ready", 32'(hreadyout), 32'd1);
    check_eq("unm_idle_resp", 32'(hresp), 32'd0);
    tick();
    check_eq("unm_idle_ready2", 32'(hreadyout), 32'd1);
    bus_idle();

    // Duplicate tags: lowest index wins
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0100_0000;
    #1 check_eq("dup_s_sel", 32'(dup_s_sel), 32'h2);
    bus_idle();
    tick();

    // Watchdog on slave 3 held for 10 wait cycles
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0300_0000;
    tick();
    bus_idle();
    s_hreadyout[3] = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check_eq("wd_before_irq", 32'(timeout_irq), 32'd0);
    tick();
    check_eq("wd_irq", 32'(timeout_irq), 32'd1);
    check_eq("wd_to_slv", 32'(to_slv), 32'd3);
    tick(); tick();
    check_eq("wd_irq_sticky", 32'(timeout_irq), 32'd1);
    s_hreadyout[3] = 1'b1;
    tick();
    timeout_clr = 1'b1;
    #1 check_eq("wd_irq_pre_clr", 32'(timeout_irq), 32'd1);
    tick();
    timeout_clr = 1'b0;
    check_eq("wd_irq_cleared", 32'(timeout_irq), 32'd0);

    // Clear coincident with a new timeout on slave 1: set wins
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0100_0000;
    tick();
    bus_idle();
    s_hreadyout[1] = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    check_eq("wd_set_wins", 32'(timeout_irq), 32'd1);
    check_eq("wd_to_slv1", 32'(to_slv), 32'd1);
    s_hreadyout[1] = 1'b1;
    tick();

    // Second timeout while flagged keeps the first index
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0200_0000;
    tick();
    bus_idle();
    s_hreadyout[2] = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    check_eq("wd_no_overwrite", 32'(to_slv), 32'd1);
    s_hreadyout[2] = 1'b1;
    tick();

    // Reset asserted during ERR1
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0700_0000;
    tick();
    bus_idle();
    #1 check_eq("pre_rst_err1", 32'(hreadyout), 32'd0);
    HRESETn = 1'b0;
    #1;
    check_eq("rstw_hreadyout", 32'(hreadyout), 32'd1);
    check_eq("rstw_hresp", 32'(hresp), 32'd0);
    check_eq("rstw_hrdata", hrdata, 32'hBADDBEEF);
    check_eq("rstw_irq", 32'(timeout_irq), 32'd0);
    check_eq("rstw_to_slv", 32'(to_slv), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
